// File: rtl/dbus_sched_pkg.sv
// rtl/dbus_sched_pkg.sv - shared constants and types for the DDR bus scheduler
//
// Purpose : common widths, requester identifiers and FSM state encoding used
//           by dbus_sched and dbus_age_prio.
// Contents: CACHELINE512 data width, requester ids, age counter width,
//           dbus_sched_state_e plus legacy-compatible state constants.
package dbus_sched_pkg;

  localparam int CACHELINE512 = 512;

  localparam int DBUS_REQ_DCACHE = 0;
  localparam int DBUS_REQ_ICACHE = 1;

  // Age counters must hold STARVE_LIMIT, which is at most 15.
  localparam int AGE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dbus_sched_state_e;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;

endpackage

// File: rtl/dbus_sched_age_prio.sv
// rtl/dbus_sched_age_prio.sv - fixed-priority arbiter with starvation aging
//
// Purpose : picks a one-hot winner among valid requesters. The lowest index
//           normally wins; a requester that has lost STARVE_LIMIT
//           arbitrations is forced to win. Owns the per-requester age
//           counters and updates them only on acceptance cycles.
// Ports   : clock, reset_n   - clock, async active-low reset
//           req_valid        - per-requester valid
//           accept           - 1 in the cycle the scheduler takes the grant
//           grant            - one-hot winner (zero when nothing is valid)
module dbus_age_prio
  import dbus_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0]   age_q [NUM_REQ];
  logic [AGE_W-1:0]   age_d [NUM_REQ];
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] pool;

  // A saturated counter only counts while its requester is valid; requesters
  // hold valid until accepted, so qualifying with valid never hides one.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = req_valid[i] && (age_q[i] == LIMIT);
    end
  end

  // Lowest set bit of the candidate pool: x & -x.
  always_comb begin
    pool  = (|starved) ? starved : req_valid;
    grant = pool & (~pool + NUM_REQ'(1));
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      age_d[i] = age_q[i];
      if (accept) begin
        if (grant[i]) begin
          age_d[i] = '0;
        end else if (req_valid[i] && (age_q[i] < LIMIT)) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/dbus_sched.sv
// rtl/dbus_sched.sv - schedules cache requesters onto the single DDR port
//
// Purpose : arbitrates NUM_REQ requesters (0 = dcache, 1 = icache) onto one
//           DDR port with a single operation in flight. IDLE accepts a winner
//           and latches its command, ISSUE strobes chip_enable for one cycle,
//           WAIT holds the command until ddr_operation_done, RESP pulses
//           resp_done to the owner with the registered read data.
// Ports   : clock, reset_n                 - clock, async active-low reset
//           req_*                          - packed per-requester request bus
//           req_ready                      - one-hot combinational accept
//           resp_read_data, resp_done      - registered data, one-hot done
//           ddr_chip_enable, ddr_*         - latched DDR command
//           ddr_read_data, ddr_operation_done, ddr_ready - DDR status
module dbus_sched
  import dbus_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int IDX_W        = 64
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]        req_index,
  input  logic [NUM_REQ-1:0]              req_write_enable,
  input  logic [NUM_REQ-1:0]              req_burst_mode,
  input  logic [NUM_REQ*CACHELINE512-1:0] req_write_data,
  input  logic [NUM_REQ*CACHELINE512-1:0] req_write_mask,
  output logic [CACHELINE512-1:0]         resp_read_data,
  output logic [NUM_REQ-1:0]              resp_done,
  output logic                            ddr_chip_enable,
  output logic [IDX_W-1:0]                ddr_index,
  output logic                            ddr_write_enable,
  output logic                            ddr_burst_mode,
  output logic [CACHELINE512-1:0]         ddr_write_mask,
  output logic [CACHELINE512-1:0]         ddr_write_data,
  input  logic [CACHELINE512-1:0]         ddr_read_data,
  input  logic                            ddr_operation_done,
  input  logic                            ddr_ready
);

  logic [1:0]              state_q, state_d;
  logic [NUM_REQ-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    we_q, we_d;
  logic                    burst_q, burst_d;
  logic [CACHELINE512-1:0] wdata_q, wdata_d;
  logic [CACHELINE512-1:0] wmask_q, wmask_d;
  logic [CACHELINE512-1:0] rdata_q, rdata_d;

  logic [NUM_REQ-1:0]      grant;
  logic                    accept;

  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_we;
  logic                    sel_burst;
  logic [CACHELINE512-1:0] sel_wdata;
  logic [CACHELINE512-1:0] sel_wmask;

  // Gated by reset_n so req_ready drops together with the async reset.
  assign accept = reset_n && (state_q == ST_IDLE) && ddr_ready && (|req_valid);

  dbus_age_prio #(
    .NUM_REQ      (NUM_REQ),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant)
  );

  // One-hot payload mux driven by the grant.
  always_comb begin
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_burst = 1'b0;
    sel_wdata = '0;
    sel_wmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_idx   = req_index[i*IDX_W +: IDX_W];
        sel_we    = req_write_enable[i];
        sel_burst = req_burst_mode[i];
        sel_wdata = req_write_data[i*CACHELINE512 +: CACHELINE512];
        sel_wmask = req_write_mask[i*CACHELINE512 +: CACHELINE512];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    idx_d   = idx_q;
    we_d    = we_q;
    burst_d = burst_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d   = sel_idx;
          we_d    = sel_we;
          burst_d = sel_burst;
          wdata_d = sel_wdata;
          wmask_d = sel_wmask;
          owner_d = grant;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A completion in the strobe cycle skips WAIT entirely.
        if (ddr_operation_done) begin
          rdata_d = ddr_read_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ddr_operation_done) begin
          rdata_d = ddr_read_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready        = accept ? grant : '0;
  assign ddr_chip_enable  = (state_q == ST_ISSUE);
  assign resp_done        = (state_q == ST_RESP) ? owner_q : '0;
  assign resp_read_data   = rdata_q;
  assign ddr_index        = idx_q;
  assign ddr_write_enable = we_q;
  assign ddr_burst_mode   = burst_q;
  assign ddr_write_data   = wdata_q;
  assign ddr_write_mask   = wmask_q;

endmodule

// File: tb/tb_dbus_sched.sv
// tb/tb_dbus_sched.sv - self-checking bench for dbus_sched
module tb_dbus_sched;

  localparam int NR  = 2;
  localparam int LIM = 4;
  localparam int IW  = 64;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid, req_ready, req_write_enable, req_burst_mode, resp_done;
  logic [NR*IW-1:0]  req_index;
  logic [NR*512-1:0] req_write_data, req_write_mask;
  logic [511:0]      resp_read_data, ddr_write_mask, ddr_write_data, ddr_read_data;
  logic              ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
  logic              ddr_operation_done, ddr_ready;
  logic [IW-1:0]     ddr_index;

  logic [IW-1:0]     p_idx   [NR];
  logic [511:0]      p_data  [NR];
  logic [511:0]      p_mask  [NR];
  logic              p_we    [NR];
  logic              p_burst [NR];

  int n_cmp = 0;
  int n_fail = 0;
  int m_age [NR];
  int last_wait;

  dbus_sched #(.NUM_REQ(NR), .STARVE_LIMIT(LIM), .IDX_W(IW)) u_dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_index          (req_index),
    .req_write_enable   (req_write_enable),
    .req_burst_mode     (req_burst_mode),
    .req_write_data     (req_write_data),
    .req_write_mask     (req_write_mask),
    .resp_read_data     (resp_read_data),
    .resp_done          (resp_done),
    .ddr_chip_enable    (ddr_chip_enable),
    .ddr_index          (ddr_index),
    .ddr_write_enable   (ddr_write_enable),
    .ddr_burst_mode     (ddr_burst_mode),
    .ddr_write_mask     (ddr_write_mask),
    .ddr_write_data     (ddr_write_data),
    .ddr_read_data      (ddr_read_data),
    .ddr_operation_done (ddr_operation_done),
    .ddr_ready          (ddr_ready)
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_index[i*IW +: IW]        = p_idx[i];
      req_write_data[i*512 +: 512] = p_data[i];
      req_write_mask[i*512 +: 512] = p_mask[i];
      req_write_enable[i]          = p_we[i];
      req_burst_mode[i]            = p_burst[i];
    end
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r = '0;
    for (int i = 0; i < 16; i++) r = {r[479:0], 32'($urandom())};
    return r;
  endfunction

  // Reference arbitration: starved requester first, else lowest valid index.
  function automatic logic [NR-1:0] model_pick(input logic [NR-1:0] v);
    logic [NR-1:0] one = 1;
    for (int i = 0; i < NR; i++) if (v[i] && m_age[i] == LIM) return one << i;
    for (int i = 0; i < NR; i++) if (v[i]) return one << i;
    return '0;
  endfunction

  task automatic model_update(input logic [NR-1:0] v, input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) begin
      if (g[i]) m_age[i] = 0;
      else if (v[i] && m_age[i] < LIM) m_age[i] = m_age[i] + 1;
    end
  endtask

  task automatic set_payload(input int r);
    p_idx[r]   = {32'($urandom()), 32'($urandom())};
    p_data[r]  = rand512();
    p_mask[r]  = rand512();
    p_we[r]    = 1'($urandom_range(0, 1));
    p_burst[r] = 1'($urandom_range(0, 1));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, req_ready, '0);
    check({tag, "_done"}, resp_done, '0);
    check({tag, "_ce"}, ddr_chip_enable, '0);
    check({tag, "_index"}, ddr_index, '0);
    check({tag, "_we"}, ddr_write_enable, '0);
    check({tag, "_burst"}, ddr_burst_mode, '0);
    check({tag, "_mask"}, ddr_write_mask, '0);
    check({tag, "_wdata"}, ddr_write_data, '0);
    check({tag, "_rdata"}, resp_read_data, '0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clock);
    #1;
    req_valid = '0;
    ddr_operation_done = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) m_age[i] = 0;
    @(posedge clock);
    #1;
  endtask

  // Runs one full operation: acceptance, strobe, wait, response.
  // Called and returns at posedge+1 of an IDLE cycle.
  task automatic do_txn(input logic [NR-1:0] exp_g, input int delay,
                        input logic [511:0] rd, input string tag);
    int w;
    int cnt;
    logic [IW-1:0] e_idx;
    logic [511:0]  e_data, e_mask;
    logic          e_we, e_burst;
    ddr_ready = 1'b1;
    cnt = 0;
    @(negedge clock);
    while (req_ready == '0 && cnt < 20) begin
      @(negedge clock);
      cnt++;
    end
    last_wait = cnt;
    check({tag, "_grant"}, req_ready, exp_g);
    if (req_ready == '0) return;
    w = exp_g[1] ? 1 : 0;
    e_idx = p_idx[w]; e_data = p_data[w]; e_mask = p_mask[w];
    e_we = p_we[w]; e_burst = p_burst[w];
    model_update(req_valid, exp_g);
    @(posedge clock);
    #1;
    req_valid[w] = 1'b0;
    if (delay == 0) begin
      ddr_operation_done = 1'b1;
      ddr_read_data = rd;
    end
    @(negedge clock);
    check({tag, "_ce"}, ddr_chip_enable, 1'b1);
    check({tag, "_index"}, ddr_index, e_idx);
    check({tag, "_we"}, ddr_write_enable, e_we);
    check({tag, "_burst"}, ddr_burst_mode, e_burst);
    check({tag, "_wdata"}, ddr_write_data, e_data);
    check({tag, "_mask"}, ddr_write_mask, e_mask);
    for (int k = 1; k <= delay; k++) begin
      @(posedge clock);
      #1;
      if (k == delay) begin
        ddr_operation_done = 1'b1;
        ddr_read_data = rd;
      end
      @(negedge clock);
      check({tag, "_wait_ce"}, ddr_chip_enable, 1'b0);
      check({tag, "_wait_hold"}, {ddr_index, ddr_write_enable, ddr_burst_mode, ddr_write_mask[63:0]},
            {e_idx, e_we, e_burst, e_mask[63:0]});
      check({tag, "_wait_done"}, resp_done, '0);
    end
    @(posedge clock);
    #1;
    ddr_operation_done = 1'b0;
    ddr_read_data = rand512();
    @(negedge clock);
    check({tag, "_resp_done"}, resp_done, exp_g);
    check({tag, "_resp_data"}, resp_read_data, rd);
    check({tag, "_resp_ready"}, req_ready, '0);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    int            who;
    logic [63:0]   idx;
    logic          we;
    logic          burst;
    logic [511:0]  data;
    logic [511:0]  mask;
    int            delay;
    logic [511:0]  rd;
    logic [NR-1:0] exp_grant;
  } vec_t;

  vec_t tbl[6];
  int   order[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    req_valid = '0;
    ddr_ready = 1'b0;
    ddr_operation_done = 1'b0;
    ddr_read_data = '0;
    for (int i = 0; i < NR; i++) begin
      p_idx[i] = '0; p_data[i] = '0; p_mask[i] = '0; p_we[i] = 1'b0; p_burst[i] = 1'b0;
      m_age[i] = 0;
    end
    #3;
    check_zero("reset");
    apply_reset("reset2");

    // Directed vectors; ages start from zero after reset.
    tbl[0] = '{2'b10, 1, 64'h8000_0040, 1'b0, 1'b0, '0, '0, 3, {16{32'hA5A5A5A5}}, 2'b10};
    tbl[1] = '{2'b01, 0, 64'h100, 1'b1, 1'b0, 512'h1234, {512{1'b1}}, 2, {16{32'h5A5A0F0F}}, 2'b01};
    tbl[2] = '{2'b11, 0, 64'h2000, 1'b0, 1'b1, {16{32'h11112222}}, {16{32'h0F0F0F0F}}, 0,
               {16{32'hDEADBEEF}}, 2'b01};
    tbl[3] = '{2'b10, 1, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1'b1, {16{32'h0BADF00D}},
               {8{64'hFF00_FF00_FF00_FF00}}, 1, {16{32'hCAFEF00D}}, 2'b10};
    tbl[4] = '{2'b11, 0, 64'h40, 1'b0, 1'b0, {16{32'h33334444}}, '0, 6, {16{32'h13572468}}, 2'b01};
    tbl[5] = '{2'b10, 1, 64'h7F, 1'b1, 1'b0, {16{32'h55556666}}, {16{32'hFFFF0000}}, 4,
               {16{32'h9ABCDEF0}}, 2'b10};
    for (int n = 0; n < 6; n++) begin
      int o;
      o = 1 - tbl[n].who;
      p_idx[tbl[n].who] = tbl[n].idx;    p_idx[o] = ~tbl[n].idx;
      p_we[tbl[n].who] = tbl[n].we;      p_we[o] = ~tbl[n].we;
      p_burst[tbl[n].who] = tbl[n].burst; p_burst[o] = ~tbl[n].burst;
      p_data[tbl[n].who] = tbl[n].data;  p_data[o] = ~tbl[n].data;
      p_mask[tbl[n].who] = tbl[n].mask;  p_mask[o] = ~tbl[n].mask;
      req_valid = tbl[n].valid;
      do_txn(tbl[n].exp_grant, tbl[n].delay, tbl[n].rd, $sformatf("vec%0d", n));
      check($sformatf("vec%0d_accept_latency", n), 512'(last_wait), '0);
      req_valid = '0;
    end

    // Aging: both requesters always valid.
    apply_reset("reset_age");
    order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    set_payload(0);
    set_payload(1);
    req_valid = 2'b11;
    for (int n = 0; n < 10; n++) begin
      logic [NR-1:0] g;
      g = (order[n] == 1) ? 2'b10 : 2'b01;
      do_txn(g, $urandom_range(0, 3), rand512(), $sformatf("age%0d", n));
      check($sformatf("age%0d_icache_age", n), 512'(u_dut.u_prio.age_q[1]), 512'(m_age[1]));
      set_payload(order[n]);
      req_valid = 2'b11;
    end

    // Back-pressure: nothing accepted while ddr_ready is low.
    ddr_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      check("bp_ready", req_ready, '0);
      check("bp_ce", ddr_chip_enable, 1'b0);
      @(posedge clock);
      #1;
    end
    do_txn(2'b01, 2, rand512(), "bp_release");
    check("bp_accept_latency", 512'(last_wait), '0);
    req_valid = '0;

    // Async reset while in WAIT, then a late completion must be ignored.
    set_payload(0);
    req_valid = 2'b01;
    ddr_ready = 1'b1;
    @(posedge clock);
    #1;
    req_valid = '0;
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("rst_wait");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) m_age[i] = 0;
    @(posedge clock);
    #1;
    ddr_operation_done = 1'b1;
    ddr_read_data = {16{32'hFEEDFACE}};
    @(posedge clock);
    #1;
    ddr_operation_done = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      check("late_done_resp", resp_done, '0);
      check("late_done_rdata", resp_read_data, '0);
      @(posedge clock);
      #1;
    end
    set_payload(1);
    req_valid = 2'b10;
    do_txn(2'b10, 1, rand512(), "post_reset");
    check("post_reset_latency", 512'(last_wait), '0);
    req_valid = '0;

    // Randomized traffic against the reference model.
    apply_reset("reset_rnd");
    for (int n = 0; n < 60; n++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req_valid[r] && $urandom_range(0, 1) == 1) begin
          set_payload(r);
          req_valid[r] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        int r;
        r = $urandom_range(0, NR - 1);
        set_payload(r);
        req_valid[r] = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        ddr_ready = 1'b0;
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          @(negedge clock);
          check("rnd_bp_ready", req_ready, '0);
          @(posedge clock);
          #1;
        end
      end
      do_txn(model_pick(req_valid), $urandom_range(0, 4), rand512(), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
